// File: rtl/c_table_arbiter_if.sv
// rtl/c_table_arbiter_if.sv - request and response channels between search lanes and the C-table arbiter
interface c_table_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_symbol;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic [ID_W-1:0]      rsp_id;

    modport master (
        output req_valid, req_symbol, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_symbol, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/c_table_arbiter.sv
// rtl/c_table_arbiter.sv - round-robin sharing of one C-table ROM among backward-search lanes
module c_table_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    c_table_arbiter_if.slave   bus,
    output logic               rom_ce_o,
    output logic [1:0]         rom_symbol_o,
    input  logic [7:0]         rom_data_i,
    output logic               busy_o,
    output logic [COUNT_W-1:0] lookup_cnt_o
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]         sym_q, sym_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic [ID_W-1:0]    winner;
    logic               found;

    // Scan lanes starting at rr_ptr so the most recently served lane goes last.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        sym_d         = sym_q;
        id_d          = id_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_id_d      = rsp_id_q;
        cnt_d         = cnt_q;
        bus.req_ready = '0;
        rom_ce_o      = 1'b0;
        rom_symbol_o  = 2'b00;
        case (state_q)
            S_IDLE: begin
                // A grant during reset would be lost, so never advertise one.
                if (found && !rst) begin
                    bus.req_ready = NUM_REQ'(1) << winner;
                    sym_d         = bus.req_symbol[2*int'(winner) +: 2];
                    id_d          = winner;
                    rr_ptr_d      = ID_W'((int'(winner) + 1) % NUM_REQ);
                    state_d       = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                rom_ce_o     = 1'b1;
                rom_symbol_o = sym_q;
                rsp_data_d   = rom_data_i;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cnt_q != {COUNT_W{1'b1}}) begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            sym_q       <= 2'b00;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_id_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sym_q       <= sym_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy_o        = (state_q != S_IDLE);
    assign lookup_cnt_o  = cnt_q;
endmodule

// File: tb/tb_c_table_arbiter.sv
// tb/tb_c_table_arbiter.sv - directed self-checking bench for c_table_arbiter
module tb_c_table_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    c_table_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();
    c_table_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus4 ();

    logic        rom_ce, rom_ce4;
    logic [1:0]  rom_symbol, rom_symbol4;
    logic [7:0]  rom_data, rom_data4;
    logic        busy, busy4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    function automatic logic [7:0] c_of(input logic [1:0] s);
        case (s)
            2'b00:   c_of = 8'd0;
            2'b01:   c_of = 8'd5;
            2'b10:   c_of = 8'd9;
            default: c_of = 8'd14;
        endcase
    endfunction

    assign rom_data  = rom_ce  ? c_of(rom_symbol)  : 8'h00;
    assign rom_data4 = rom_ce4 ? c_of(rom_symbol4) : 8'h00;

    // Narrow-counter copy runs in lockstep on the same inputs.
    assign bus4.req_valid  = bus.req_valid;
    assign bus4.req_symbol = bus.req_symbol;
    assign bus4.rsp_ready  = bus.rsp_ready;

    c_table_arbiter #(.NUM_REQ(4), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rom_ce_o(rom_ce), .rom_symbol_o(rom_symbol), .rom_data_i(rom_data),
        .busy_o(busy), .lookup_cnt_o(cnt)
    );

    c_table_arbiter #(.NUM_REQ(4), .COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .rom_ce_o(rom_ce4), .rom_symbol_o(rom_symbol4), .rom_data_i(rom_data4),
        .busy_o(busy4), .lookup_cnt_o(cnt4)
    );

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_symbol = 8'h00;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        step();
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_rom_ce: got %b expected 0", rom_ce); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        bus.req_valid = 4'h0;
        exp_cnt = 0;
        step();
    endtask

    task automatic test_single;
        bus.req_valid = 4'b0100;
        bus.req_symbol = 8'b00_10_00_00;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        checks++; if (rom_ce !== 1'b1 || rom_symbol !== 2'b10) begin errors++; $display("FAIL single_rom: got ce=%b sym=%b expected ce=1 sym=10", rom_ce, rom_symbol); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        step();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'd9 || bus.rsp_id !== 2'd2) begin
            errors++; $display("FAIL single_rsp: got v=%b d=%0d id=%0d expected v=1 d=9 id=2", bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
        exp_cnt++;
        step();
        checks++; if (bus.rsp_valid !== 1'b0 || cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL single_ack: got v=%b cnt=%0d expected v=0 cnt=%0d", bus.rsp_valid, cnt, exp_cnt); end
        checks++; if (bus.rsp_data !== 8'd9 || bus.rsp_id !== 2'd2) begin errors++; $display("FAIL single_hold: got d=%0d id=%0d expected d=9 id=2", bus.rsp_data, bus.rsp_id); end
    endtask

    task automatic test_fairness;
        logic [7:0] exp_data [4];
        exp_data = '{8'd14, 8'd5, 8'd9, 8'd0};
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        bus.req_valid = 4'hF;
        bus.req_symbol = 8'b00_10_01_11;
        bus.rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 6; g++) begin
            checks++; if (bus.req_ready !== (4'b0001 << (g % 4))) begin
                errors++; $display("FAIL fair_grant%0d: got %b expected lane %0d", g, bus.req_ready, g % 4); end
            step();
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL fair_no_grant%0d: got %b expected 0000", g, bus.req_ready); end
            step();
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data[g % 4] || bus.rsp_id !== 2'(g % 4)) begin
                errors++; $display("FAIL fair_rsp%0d: got v=%b d=%0d id=%0d expected v=1 d=%0d id=%0d", g, bus.rsp_valid, bus.rsp_data, bus.rsp_id, exp_data[g % 4], g % 4); end
            exp_cnt++;
            if (g == 5) bus.req_valid = 4'h0;
            step();
        end
        checks++; if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL fair_cnt: got %0d expected %0d", cnt, exp_cnt); end
    endtask

    task automatic test_backpressure;
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", bus.req_ready); end
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'd9 || bus.rsp_id !== 2'd2) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b d=%0d id=%0d expected v=1 d=9 id=2", i, bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
            checks++; if (bus.req_ready !== 4'b0000 || rom_ce !== 1'b0 || cnt !== 16'(exp_cnt)) begin
                errors++; $display("FAIL bp_idle%0d: got rdy=%b ce=%b cnt=%0d expected rdy=0000 ce=0 cnt=%0d", i, bus.req_ready, rom_ce, cnt, exp_cnt); end
            step();
        end
        bus.rsp_ready = 1'b1;
        exp_cnt++;
        step();
        checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL bp_release: got busy=%b v=%b cnt=%0d expected busy=0 v=0 cnt=%0d", busy, bus.rsp_valid, cnt, exp_cnt); end
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b expected 1000", bus.req_ready); end
        step();
        bus.req_valid = 4'h0;
        checks++; if (rom_ce !== 1'b1 || rom_symbol !== 2'b00) begin errors++; $display("FAIL bp_next_rom: got ce=%b sym=%b expected ce=1 sym=00", rom_ce, rom_symbol); end
        step();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'd0 || bus.rsp_id !== 2'd3) begin
            errors++; $display("FAIL bp_next_rsp: got v=%b d=%0d id=%0d expected v=1 d=0 id=3", bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
        exp_cnt++;
        step();
    endtask

    task automatic test_reset_mid;
        bus.req_valid = 4'b0011;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_grant: got %b expected 0001", bus.req_ready); end
        step();
        rst = 1'b1;
        checks++; if (rom_ce !== 1'b1) begin errors++; $display("FAIL rmid_lookup: got ce=%b expected 1", rom_ce); end
        step();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || cnt !== 16'd0 || cnt4 !== 4'd0) begin
            errors++; $display("FAIL rmid_state: got busy=%b v=%b cnt=%0d cnt4=%0d expected 0 0 0 0", busy, bus.rsp_valid, cnt, cnt4); end
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_rrptr: got %b expected 0001", bus.req_ready); end
        bus.req_valid = 4'h0;
        step();
    endtask

    task automatic test_saturation;
        bus.req_valid = 4'b0001;
        bus.req_symbol = 8'b00_00_00_11;
        bus.rsp_ready = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            step();
            if (n == 20) bus.req_valid = 4'h0;
            step();
            exp_cnt++;
            checks++; if (cnt4 !== 4'((n > 15) ? 15 : n) || cnt !== 16'(exp_cnt)) begin
                errors++; $display("FAIL sat_%0d: got cnt4=%0d cnt=%0d expected cnt4=%0d cnt=%0d", n, cnt4, cnt, (n > 15) ? 15 : n, exp_cnt); end
        end
        step();
        step();
        checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", cnt4); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
